// File: rtl/gnn_mac_scheduler.sv
// gnn_mac_scheduler: two-layer GNN forward pass on one shared unsigned MAC.
// Layer 1 fills an internal hidden buffer; layer 2 streams results over valid/ready.
// Optional build macro GNN_PERF_CNT_EN adds perf_cycles / perf_stalls counters.
module gnn_mac_scheduler #(
  parameter int unsigned NODES    = 4,
  parameter int unsigned IN_FEAT  = 4,
  parameter int unsigned HID      = 4,
  parameter int unsigned OUT_FEAT = 2,
  parameter int unsigned DW       = 5,
  parameter int unsigned HW       = 12,
  parameter int unsigned AW       = 20,
  localparam int unsigned NW = (NODES > 1) ? $clog2(NODES) : 1,
  localparam int unsigned IW = (IN_FEAT > 1) ? $clog2(IN_FEAT) : 1,
  localparam int unsigned JW = (HID > 1) ? $clog2(HID) : 1,
  localparam int unsigned KW = (OUT_FEAT > 1) ? $clog2(OUT_FEAT) : 1,
  localparam int unsigned RW = ((IN_FEAT > HID ? IN_FEAT : HID) > 1) ? $clog2(IN_FEAT > HID ? IN_FEAT : HID) : 1,
  localparam int unsigned CW = ((HID > OUT_FEAT ? HID : OUT_FEAT) > 1) ? $clog2(HID > OUT_FEAT ? HID : OUT_FEAT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] x_node,
  output logic [IW-1:0] x_feat,
  output logic          w_layer,
  output logic [RW-1:0] w_row,
  output logic [CW-1:0] w_col,
  input  logic [DW-1:0] x_data,
  input  logic [DW-1:0] w_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_data,
  output logic [NW-1:0] res_node,
  output logic [KW-1:0] res_idx
`ifdef GNN_PERF_CNT_EN
  ,
  output logic [15:0]   perf_cycles,
  output logic [15:0]   perf_stalls
`endif
);

  localparam logic [NW-1:0] N_LAST = NW'(NODES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(IN_FEAT - 1);
  localparam logic [JW-1:0] J_LAST = JW'(HID - 1);
  localparam logic [KW-1:0] K_LAST = KW'(OUT_FEAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_OUT_WAIT, S_DONE} state_t;

  state_t        state, state_d;
  logic [NW-1:0] n, n_d;
  logic [IW-1:0] i, i_d;
  logic [JW-1:0] j, j_d;
  logic [KW-1:0] k, k_d;
  logic [AW-1:0] acc, acc_d;
  logic [AW-1:0] op_a, mac_term, mac_sum;
  logic          mac_first;
  logic          busy_d, done_d, w_layer_d, res_valid_d;
  logic [AW-1:0] res_data_d;
  logic [NW-1:0] res_node_d, x_node_d;
  logic [KW-1:0] res_idx_d;
  logic [IW-1:0] x_feat_d;
  logic [RW-1:0] w_row_d;
  logic [CW-1:0] w_col_d;

  logic [HW-1:0] hbuf [NODES][HID];

  // Shared MAC: operand source depends on layer; first term of each dot product restarts the sum
  always_comb begin
    op_a      = (state == S_L2) ? AW'(hbuf[n][j]) : AW'(x_data);
    mac_term  = op_a * AW'(w_data);
    mac_first = (state == S_L2) ? (j == '0) : (i == '0);
    mac_sum   = mac_first ? mac_term : (acc + mac_term);
  end

  // Next-state, counter and output computation
  always_comb begin
    state_d     = state;
    n_d         = n;
    i_d         = i;
    j_d         = j;
    k_d         = k;
    acc_d       = acc;
    busy_d      = busy;
    done_d      = 1'b0;
    w_layer_d   = w_layer;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    res_node_d  = res_node;
    res_idx_d   = res_idx;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d   = S_L1;
          n_d       = '0;
          i_d       = '0;
          j_d       = '0;
          k_d       = '0;
          acc_d     = '0;
          busy_d    = 1'b1;
          w_layer_d = 1'b0;
        end
      end
      S_L1: begin
        acc_d = mac_sum;
        if (i == I_LAST) begin
          i_d = '0;
          if (j == J_LAST) begin
            j_d = '0;
            if (n == N_LAST) begin
              n_d       = '0;
              k_d       = '0;
              state_d   = S_L2;
              w_layer_d = 1'b1;
            end else begin
              n_d = n + NW'(1);
            end
          end else begin
            j_d = j + JW'(1);
          end
        end else begin
          i_d = i + IW'(1);
        end
      end
      S_L2: begin
        acc_d = mac_sum;
        if (j == J_LAST) begin
          res_data_d  = mac_sum;
          res_node_d  = n;
          res_idx_d   = k;
          res_valid_d = 1'b1;
          state_d     = S_OUT_WAIT;
        end else begin
          j_d = j + JW'(1);
        end
      end
      S_OUT_WAIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          j_d         = '0;
          if ((n == N_LAST) && (k == K_LAST)) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            w_layer_d = 1'b0;
          end else begin
            state_d = S_L2;
            if (k == K_LAST) begin
              k_d = '0;
              n_d = n + NW'(1);
            end else begin
              k_d = k + KW'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        n_d     = '0;
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        acc_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    // Operand selects follow the counters of the state being entered
    x_node_d = (state_d == S_L1) ? n_d : '0;
    x_feat_d = (state_d == S_L1) ? i_d : '0;
    if (state_d == S_L1) begin
      w_row_d = RW'(i_d);
      w_col_d = CW'(j_d);
    end else if ((state_d == S_L2) || (state_d == S_OUT_WAIT)) begin
      w_row_d = RW'(j_d);
      w_col_d = CW'(k_d);
    end else begin
      w_row_d = '0;
      w_col_d = '0;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      n         <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_layer   <= 1'b0;
      x_node    <= '0;
      x_feat    <= '0;
      w_row     <= '0;
      w_col     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_node  <= '0;
      res_idx   <= '0;
    end else begin
      state     <= state_d;
      n         <= n_d;
      i         <= i_d;
      j         <= j_d;
      k         <= k_d;
      acc       <= acc_d;
      busy      <= busy_d;
      done      <= done_d;
      w_layer   <= w_layer_d;
      x_node    <= x_node_d;
      x_feat    <= x_feat_d;
      w_row     <= w_row_d;
      w_col     <= w_col_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      res_node  <= res_node_d;
      res_idx   <= res_idx_d;
    end
  end

  // Hidden buffer write at the last term of each layer-1 dot product
  always_ff @(posedge clk) begin
    if ((state == S_L1) && (i == I_LAST)) begin
      hbuf[n][j] <= HW'(mac_sum);
    end
  end

`ifdef GNN_PERF_CNT_EN
  // Saturating busy-cycle and output-stall counters, cleared on accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if ((state == S_IDLE) && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && (perf_cycles != 16'hFFFF)) begin
        perf_cycles <= perf_cycles + 16'd1;
      end
      if ((state == S_OUT_WAIT) && !res_ready && (perf_stalls != 16'hFFFF)) begin
        perf_stalls <= perf_stalls + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gnn_mac_scheduler.sv
// Self-checking bench for gnn_mac_scheduler: table of uniform-operand passes
// plus directed sequences for layer-1 values, backpressure, mid-pass start and abort.
module tb_gnn_mac_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        res_ready = 1'b0;
  logic        busy, done, w_layer, res_valid;
  logic [1:0]  x_node, x_feat, w_row, w_col, res_node;
  logic [0:0]  res_idx;
  logic [4:0]  x_data, w_data;
  logic [19:0] res_data;
`ifdef GNN_PERF_CNT_EN
  logic [15:0] perf_cycles, perf_stalls;
`endif

  logic [4:0]  xm  [4][4];
  logic [4:0]  w1m [4][4];
  logic [4:0]  w2m [4][4];
  logic [19:0] exp_res [8];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  xv;
    logic [4:0]  w1v;
    logic [4:0]  w2v;
    logic [19:0] expv;
  } vec_t;

  gnn_mac_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .x_node(x_node), .x_feat(x_feat), .w_layer(w_layer), .w_row(w_row), .w_col(w_col),
    .x_data(x_data), .w_data(w_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_node(res_node), .res_idx(res_idx)
`ifdef GNN_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Combinational operand register file
  assign x_data = xm[x_node][x_feat];
  assign w_data = w_layer ? w2m[w_row][w_col] : w1m[w_row][w_col];

  task automatic chk(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic fill_uniform(input logic [4:0] xv, input logic [4:0] w1v, input logic [4:0] w2v);
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        xm[a][b]  = xv;
        w1m[a][b] = w1v;
        w2m[a][b] = w2v;
      end
    end
  endtask

  // One full pass; bp = ready-low cycles at the first result, mid_start pulses start at cycle 30
  task automatic run_pass(input string tag, input int bp, input bit mid_start);
    int e, nres, first_v, done_e, stall_left, unstable;
    logic [19:0] s_data;
    logic [1:0]  s_node, s_xn, s_xf, s_row, s_col;
    logic [0:0]  s_idx;
    logic        s_wl;
    res_ready = (bp == 0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = 0; nres = 0; first_v = -1; done_e = -1; stall_left = bp; unstable = 0;
    chk({tag, "_busy_after_start"}, busy, 1);
    while (done_e < 0 && e < 400) begin
      start = mid_start && (e == 30);
      if (res_valid && first_v < 0) begin
        first_v = e;
        s_data = res_data; s_node = res_node; s_idx = res_idx;
        s_xn = x_node; s_xf = x_feat; s_row = w_row; s_col = w_col; s_wl = w_layer;
      end
      if (done) begin
        done_e = e;
        chk({tag, "_busy_with_done"}, busy, 1);
      end
      if (res_valid && stall_left > 0) begin
        if (e != first_v) begin
          if (res_data != s_data || res_node != s_node || res_idx != s_idx ||
              x_node != s_xn || x_feat != s_xf || w_row != s_row || w_col != s_col ||
              w_layer != s_wl || !res_valid)
            unstable++;
        end
        stall_left--;
        res_ready = 1'b0;
      end else begin
        res_ready = 1'b1;
      end
      if (res_valid && res_ready) begin
        if (nres < 8) begin
          chk($sformatf("%s_res%0d_node", tag, nres), res_node, nres / 2);
          chk($sformatf("%s_res%0d_idx", tag, nres), res_idx, nres % 2);
          chk($sformatf("%s_res%0d_data", tag, nres), res_data, exp_res[nres]);
        end
        nres++;
      end
      @(posedge clk);
      #1;
      e++;
    end
    start = 1'b0;
    chk({tag, "_result_count"}, nres, 8);
    chk({tag, "_first_valid_cycle"}, first_v, 68);
    chk({tag, "_done_cycle"}, done_e, 104 + bp);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_busy_after_done"}, busy, 0);
    chk({tag, "_valid_after_done"}, res_valid, 0);
    if (bp > 0) chk({tag, "_stall_stable"}, unstable, 0);
`ifdef GNN_PERF_CNT_EN
    chk({tag, "_perf_cycles"}, perf_cycles, 105 + bp);
    chk({tag, "_perf_stalls"}, perf_stalls, bp);
`endif
  endtask

  initial begin
    vec_t vecs [5];
    vecs[0] = '{xv: 5'd1,  w1v: 5'd1,  w2v: 5'd1,  expv: 20'd16};
    vecs[1] = '{xv: 5'd2,  w1v: 5'd3,  w2v: 5'd5,  expv: 20'd480};
    vecs[2] = '{xv: 5'd31, w1v: 5'd31, w2v: 5'd31, expv: 20'd476656};
    vecs[3] = '{xv: 5'd0,  w1v: 5'd9,  w2v: 5'd9,  expv: 20'd0};
    vecs[4] = '{xv: 5'd31, w1v: 5'd1,  w2v: 5'd2,  expv: 20'd992};

    // Reset with random inputs: every output low
    fill_uniform(5'($urandom), 5'($urandom), 5'($urandom));
    start = 1'($urandom);
    res_ready = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {busy, done, w_layer, res_valid, x_node, x_feat, w_row, w_col,
                        res_node, res_idx, res_data}, 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      chk("idle_hold", {busy, done, res_valid, w_layer}, 0);
    end

    // Uniform-operand table
    for (int v = 0; v < 5; v++) begin
      fill_uniform(vecs[v].xv, vecs[v].w1v, vecs[v].w2v);
      for (int r = 0; r < 8; r++) exp_res[r] = vecs[v].expv;
      run_pass($sformatf("vec%0d", v), 0, 1'b0);
    end

    // Layer-1 dot product through a single nonzero layer-2 weight
    fill_uniform(5'd0, 5'd0, 5'd0);
    xm[0][0] = 5'd4; xm[0][1] = 5'd2; xm[0][2] = 5'd4; xm[0][3] = 5'd1;
    w1m[0][0] = 5'd3; w1m[1][0] = 5'd2; w1m[2][0] = 5'd13; w1m[3][0] = 5'd26;
    w2m[0][0] = 5'd1;
    for (int r = 0; r < 8; r++) exp_res[r] = 20'd0;
    exp_res[0] = 20'd94;
    run_pass("layer1", 0, 1'b0);

    // Backpressure at the first result
    fill_uniform(5'd1, 5'd1, 5'd1);
    for (int r = 0; r < 8; r++) exp_res[r] = 20'd16;
    run_pass("backpressure", 10, 1'b0);

    // Max operands with a start pulse mid-pass
    fill_uniform(5'd31, 5'd31, 5'd31);
    for (int r = 0; r < 8; r++) exp_res[r] = 20'd476656;
    run_pass("max_midstart", 0, 1'b1);

    // Abort during layer 2, then a fresh pass
    fill_uniform(5'd1, 5'd1, 5'd1);
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (66) @(posedge clk);
    #1;
    chk("abort_in_l2", w_layer, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, w_layer, res_valid, x_node, x_feat, w_row, w_col,
                          res_node, res_idx, res_data}, 0);
`ifdef GNN_PERF_CNT_EN
    chk("abort_perf", {perf_cycles, perf_stalls}, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) exp_res[r] = 20'd16;
    run_pass("after_abort", 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
